// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding
// and the store-width encodings also decoded by execute.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_WAIT = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_RESP = 2'd3
  } dmem_state_t;

  localparam logic [2:0] WR_W_BYTE = 3'd1;
  localparam logic [2:0] WR_W_HALF = 3'd2;
  localparam logic [2:0] WR_W_WORD = 3'd4;

  function automatic logic width_is_valid(input logic [2:0] w);
    return (w == WR_W_BYTE) || (w == WR_W_HALF) || (w == WR_W_WORD);
  endfunction

  function automatic logic [3:0] width_to_be(input logic [2:0] w);
    case (w)
      WR_W_BYTE: return 4'b0001;
      WR_W_HALF: return 4'b0011;
      WR_W_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_byte_ram.sv
// Byte-addressed RAM with four byte-enable write lanes and a four-byte read
// window starting at any address; lanes past the top read as zero.
module dmem_byte_ram #(
  parameter int    MEM_BYTES = 4096,
  parameter string INIT_FILE = "",
  parameter int    AW        = $clog2(MEM_BYTES)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  localparam logic [AW:0] MEM_TOP = (AW+1)'(MEM_BYTES);

  logic [7:0] mem_q [MEM_BYTES];
  logic [AW:0] widx_s [4];
  logic [AW:0] ridx_s [4];

  // Elaboration-time contents: all zero.
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem_q[i] = 8'd0;
    end
  end

  // Lane index generation and read window assembly.
  always_comb begin
    o_rdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      widx_s[i] = {1'b0, i_waddr} + (AW+1)'(i);
      ridx_s[i] = {1'b0, i_raddr} + (AW+1)'(i);
      if (ridx_s[i] < MEM_TOP) begin
        o_rdata[8*i +: 8] = mem_q[ridx_s[i][AW-1:0]];
      end else begin
        o_rdata[8*i +: 8] = 8'd0;
      end
    end
  end

  // Byte-lane write port.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we && i_be[i] && (widx_s[i] < MEM_TOP)) begin
        mem_q[widx_s[i][AW-1:0]] <= i_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for execute's load/store port: request capture,
// programmable latency, range/width checks and registered responses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    MEM_BYTES  = 4096,
  parameter int    RD_LATENCY = 2,
  parameter int    WR_LATENCY = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [2:0]            i_wr_width,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_err
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [3:0]  RD_LOAD  = 4'(RD_LATENCY - 1);
  localparam logic [3:0]  WR_LOAD  = 4'(WR_LATENCY - 1);
  localparam logic [32:0] MEM_SIZE = 33'(MEM_BYTES);

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            width_q, width_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic [32:0]           wr_end_s;
  logic                  wr_err_s, rd_err_s, wr_commit_s;
  logic [3:0]            be_s;
  logic [31:0]           rd_window_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Checks run on the request being held (or just captured), hence the _d view.
  assign wr_end_s    = {1'b0, addr_d} + {30'd0, width_d};
  assign wr_err_s    = !width_is_valid(width_d) || (wr_end_s > MEM_SIZE);
  assign rd_err_s    = ({1'b0, addr_d} >= MEM_SIZE);
  assign rd_data_s   = rd_err_s ? {DATA_WIDTH{1'b0}} : rd_window_s;
  assign be_s        = width_to_be(width_q);
  assign wr_commit_s = (state_q == S_WR_WAIT) && (cnt_q == 4'd0) && !wr_err_s && !i_rst;

  dmem_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_commit_s),
    .i_be    (be_s),
    .i_waddr (addr_q[AW-1:0]),
    .i_wdata (wdata_q),
    .i_raddr (addr_d[AW-1:0]),
    .o_rdata (rd_window_s)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    width_d    = width_q;
    wr_ready_d = 1'b0;
    rd_valid_d = 1'b0;
    data_d     = {DATA_WIDTH{1'b0}};
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_wr_valid) begin
          addr_d     = i_addr;
          wdata_d    = i_data;
          width_d    = i_wr_width;
          cnt_d      = WR_LOAD;
          state_d    = S_WR_WAIT;
          wr_ready_d = (WR_LOAD == 4'd0);
          err_d      = (WR_LOAD == 4'd0) && wr_err_s;
        end else if (i_rd_ready) begin
          addr_d = i_addr;
          cnt_d  = RD_LOAD;
          if (RD_LOAD == 4'd0) begin
            state_d    = S_RD_RESP;
            rd_valid_d = 1'b1;
            err_d      = rd_err_s;
            data_d     = rd_data_s;
          end else begin
            state_d = S_RD_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else if (!i_wr_valid) begin
          state_d = S_IDLE;
        end else begin
          cnt_d      = cnt_q - 4'd1;
          wr_ready_d = (cnt_d == 4'd0);
          err_d      = (cnt_d == 4'd0) && wr_err_s;
        end
      end
      S_RD_WAIT: begin
        if (!i_rd_ready) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_d == 4'd0) begin
            state_d    = S_RD_RESP;
            rd_valid_d = 1'b1;
            err_d      = rd_err_s;
            data_d     = rd_data_s;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_RESP: begin
        // Either the data is taken or the load was dropped; both end here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request capture and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= {DATA_WIDTH{1'b0}};
      width_q    <= 3'd0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      data_q     <= {DATA_WIDTH{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      width_q    <= width_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign o_wr_ready = wr_ready_q;
  assign o_rd_valid = rd_valid_q;
  assign o_data     = data_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// corner sequences and a randomized run against a byte-array memory model.
module tb_dmem_responder;

  localparam int MEM_BYTES = 4096;
  localparam int RD_LAT    = 2;
  localparam int WR_LAT    = 1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [2:0]  i_wr_width;
  logic [31:0] o_data;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  dmem_responder #(
    .DATA_WIDTH (32),
    .MEM_BYTES  (MEM_BYTES),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT),
    .INIT_FILE  ("")
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .i_wr_width (i_wr_width),
    .o_data     (o_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_err      (o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mem_model [MEM_BYTES];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  width;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  function automatic bit model_wr_err(input logic [31:0] a, input logic [2:0] w);
    longint last;
    if (!(w == 3'd1 || w == 3'd2 || w == 3'd4)) return 1'b1;
    last = {32'd0, a};
    last = last + longint'(w) - 1;
    return last >= MEM_BYTES;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    for (int i = 0; i < int'(w); i++) begin
      mem_model[int'(a) + i] = d[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a >= MEM_BYTES) return 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (int'(a) + i < MEM_BYTES) r[8*i +: 8] = mem_model[int'(a) + i];
    end
    return r;
  endfunction

  // Store: hold valid until the cycle after the ack, scrambling the bus meanwhile.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w,
                          output logic err, output int lat);
    i_addr = a; i_data = d; i_wr_width = w; i_wr_valid = 1'b1;
    lat = 0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      i_addr = $urandom; i_data = $urandom; i_wr_width = 3'($urandom);
      if (o_wr_ready) begin
        lat = k; err = o_err;
        break;
      end
    end
    cyc();
    i_wr_valid = 1'b0;
    check("wr_ready_pulse", {31'd0, o_wr_ready}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic err, output int lat);
    i_addr = a; i_rd_ready = 1'b1;
    lat = 0; err = 1'b0; data = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      i_addr = $urandom;
      if (o_rd_valid) begin
        lat = k; err = o_err; data = o_data;
        break;
      end
    end
    cyc();
    i_rd_ready = 1'b0;
    check("rd_valid_drop", {31'd0, o_rd_valid}, 32'd0);
  endtask

  initial begin
    logic        err_v;
    int          lat_v;
    logic [31:0] rd_v;
    logic        seen;

    for (int i = 0; i < MEM_BYTES; i++) mem_model[i] = 8'd0;
    i_rst = 1'b1; i_addr = 32'd0; i_data = 32'd0; i_wr_valid = 1'b0;
    i_wr_width = 3'd0; i_rd_ready = 1'b0;
    repeat (3) cyc();
    check("rst_wr_ready", {31'd0, o_wr_ready}, 32'd0);
    check("rst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_data", o_data, 32'd0);
    i_rst = 1'b0;
    cyc();

    vecs.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 3'd4, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 3'd0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h11, 32'h00000055, 3'd1, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 3'd0, 32'hDEAD55EF, 1'b0});
    vecs.push_back('{1'b0, 32'h11, 32'h0, 3'd0, 32'h00DEAD55, 1'b0});
    vecs.push_back('{1'b1, 32'(MEM_BYTES-1), 32'h00001234, 3'd2, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'(MEM_BYTES-4), 32'h0, 3'd0, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 32'h20, 32'hCAFEF00D, 3'd3, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 3'd0, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 32'(MEM_BYTES-2), 32'h000000AA, 3'd1, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'(MEM_BYTES-1), 32'h000000BB, 3'd1, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'(MEM_BYTES-2), 32'h0, 3'd0, 32'h0000BBAA, 1'b0});
    vecs.push_back('{1'b0, 32'(MEM_BYTES), 32'h0, 3'd0, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 32'h31, 32'h00009876, 3'd2, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h30, 32'h0, 3'd0, 32'h00987600, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].width, err_v, lat_v);
        check($sformatf("vec%0d_wr_lat", i), 32'(lat_v), 32'(WR_LAT));
        check($sformatf("vec%0d_wr_err", i), {31'd0, err_v}, {31'd0, vecs[i].exp_err});
        if (!vecs[i].exp_err) model_write(vecs[i].addr, vecs[i].data, vecs[i].width);
      end else begin
        do_read(vecs[i].addr, rd_v, err_v, lat_v);
        check($sformatf("vec%0d_rd_lat", i), 32'(lat_v), 32'(RD_LAT));
        check($sformatf("vec%0d_rd_data", i), rd_v, vecs[i].exp_data);
        check($sformatf("vec%0d_rd_err", i), {31'd0, err_v}, {31'd0, vecs[i].exp_err});
      end
    end

    // Store and load together: store is acked first, load follows it.
    i_addr = 32'h40; i_data = 32'h1; i_wr_width = 3'd4;
    i_wr_valid = 1'b1; i_rd_ready = 1'b1;
    cyc();
    check("both_wr_ack", {31'd0, o_wr_ready}, 32'd1);
    check("both_no_rd_early", {31'd0, o_rd_valid}, 32'd0);
    cyc();
    i_wr_valid = 1'b0;
    check("both_ack_pulse", {31'd0, o_wr_ready}, 32'd0);
    cyc();
    check("both_rd_wait", {31'd0, o_rd_valid}, 32'd0);
    cyc();
    check("both_rd_valid", {31'd0, o_rd_valid}, 32'd1);
    check("both_rd_data", o_data, 32'h00000001);
    model_write(32'h40, 32'h1, 3'd4);
    cyc();
    i_rd_ready = 1'b0;
    cyc();

    // Load dropped while waiting for data.
    i_addr = 32'h10; i_rd_ready = 1'b1;
    cyc();
    i_rd_ready = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      cyc();
      seen = seen | o_rd_valid;
    end
    check("rd_abort_no_valid", {31'd0, seen}, 32'd0);
    check("rd_abort_data", o_data, 32'd0);

    // Reset while the store is pending: nothing may be committed.
    i_addr = 32'h10; i_data = 32'h77777777; i_wr_width = 3'd4; i_wr_valid = 1'b1;
    cyc();
    i_rst = 1'b1; i_wr_valid = 1'b0;
    cyc();
    check("rst_mid_wr_ready", {31'd0, o_wr_ready}, 32'd0);
    check("rst_mid_err", {31'd0, o_err}, 32'd0);
    check("rst_mid_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    i_rst = 1'b0;
    cyc();
    do_read(32'h10, rd_v, err_v, lat_v);
    check("rst_mid_ram", rd_v, model_read(32'h10));

    // Randomized traffic against the byte-array model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, d;
      logic [2:0]  w;
      bit          e;
      if ($urandom_range(0, 3) == 0) a = 32'(MEM_BYTES - 6 + int'($urandom_range(0, 9)));
      else a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        w = 3'($urandom_range(0, 5));
        e = model_wr_err(a, w);
        do_write(a, d, w, err_v, lat_v);
        check($sformatf("rnd%0d_wr_lat", n), 32'(lat_v), 32'(WR_LAT));
        check($sformatf("rnd%0d_wr_err", n), {31'd0, err_v}, {31'd0, e});
        if (!e) model_write(a, d, w);
      end else begin
        do_read(a, rd_v, err_v, lat_v);
        check($sformatf("rnd%0d_rd_lat", n), 32'(lat_v), 32'(RD_LAT));
        check($sformatf("rnd%0d_rd_data", n), rd_v, model_read(a));
        check($sformatf("rnd%0d_rd_err", n), {31'd0, err_v}, {31'd0, a >= MEM_BYTES});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
